// File: rtl/turfio_pkg.sv
// Constants and types shared by both ends of the TURFIO parallel COUT/CIN link.
package turfio_pkg;

  localparam logic [31:0] TRAIN_SEQUENCE_DEFAULT = 32'hA55A6996;
  localparam logic [15:0] IDLE_HWORD_DEFAULT     = 16'h0000;
  localparam int          IFCLK_PHASES           = 8;

  typedef logic [2:0] ifclk_phase_t;

  // Counter value one cycle after the buffered phase pulse; the receiver uses
  // the same constant so a given offset_i means the same thing on both ends.
  localparam ifclk_phase_t PHASE_RELOAD = 3'd2;

  function automatic logic [31:0] pack_frame(
    input logic [15:0] head0,
    input logic [15:0] head1,
    input logic [15:0] idle,
    input logic        has1,
    input logic        has2
  );
    return {(has2 ? head1 : idle), (has1 ? head0 : idle)};
  endfunction

endpackage

// File: rtl/cout_hword_fifo.sv
// Halfword queue with a single push port and a 0/1/2-entry pop per cycle;
// exposes the two oldest entries so a whole frame can be built in one cycle.
module cout_hword_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic [1:0]             pop,
  output logic [WIDTH-1:0]       head0,
  output logic [WIDTH-1:0]       head1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_rd_ptr_p1;
  logic [AW:0]      r_count;

  assign w_rd_ptr_p1 = r_rd_ptr + AW'(1);
  assign head0       = r_mem[r_rd_ptr];
  assign head1       = r_mem[w_rd_ptr_p1];
  assign count       = r_count;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // The caller never pops more than count, so pop and push can be summed
  // freely even when both happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= r_rd_ptr + AW'(pop);
      r_count  <= r_count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

endmodule

// File: rtl/turfio_cout_parallel_tx.sv
// COUT parallel transmitter: one 32-bit frame per 8 IFCLK cycles, sent 4 bits
// per cycle LSB-first, aligned to the IFCLK phase plus a programmable offset.
module turfio_cout_parallel_tx
  import turfio_pkg::*;
#(
  parameter logic [31:0] TRAIN_SEQUENCE = TRAIN_SEQUENCE_DEFAULT,
  parameter logic [15:0] IDLE_HWORD     = IDLE_HWORD_DEFAULT,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        ifclk_i,
  input  logic        rst_i,
  input  logic        ifclk_phase_i,
  input  logic [2:0]  offset_i,
  input  logic        enable_i,
  input  logic        train_i,
  input  logic [15:0] dat_i,
  input  logic        dat_valid_i,
  output logic        dat_ready_o,
  output logic [3:0]  cout_o,
  output logic        frame_start_o,
  output logic        training_o
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic         r_alive;
  logic         r_phase_buf;
  ifclk_phase_t r_phase_cnt;
  logic         r_load;
  logic [31:0]  r_shift;
  logic         r_frame_start;
  logic         r_training;

  logic [CW-1:0] w_count;
  logic [15:0]   w_head0;
  logic [15:0]   w_head1;
  logic          w_data_mode;
  logic          w_has1;
  logic          w_has2;
  logic          w_push;
  logic [1:0]    w_pop;
  logic [31:0]   w_word;

  assign w_data_mode = enable_i && !train_i;
  assign w_has1      = (w_count != '0);
  assign w_has2      = (w_count > CW'(1));
  assign w_word      = w_data_mode ? pack_frame(w_head0, w_head1, IDLE_HWORD, w_has1, w_has2)
                                   : TRAIN_SEQUENCE;

  // r_alive keeps ready low through reset and until the first edge after it.
  assign dat_ready_o = r_alive && enable_i && (w_count < DEPTH_C);
  assign w_push      = dat_valid_i && dat_ready_o;

  always_comb begin
    w_pop = 2'd0;
    if (r_load && w_data_mode) begin
      w_pop = w_has2 ? 2'd2 : {1'b0, w_has1};
    end
  end

  cout_hword_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (ifclk_i),
    .rst   (rst_i),
    .flush (!enable_i),
    .push  (w_push),
    .din   (dat_i),
    .pop   (w_pop),
    .head0 (w_head0),
    .head1 (w_head1),
    .count (w_count)
  );

  // Between loads the shift register drains with zero fill, so an offset
  // change only stretches or truncates one frame.
  always_ff @(posedge ifclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alive       <= 1'b0;
      r_phase_buf   <= 1'b0;
      r_phase_cnt   <= '0;
      r_load        <= 1'b0;
      r_shift       <= '0;
      r_frame_start <= 1'b0;
      r_training    <= 1'b1;
    end else begin
      r_alive       <= 1'b1;
      r_phase_buf   <= ifclk_phase_i;
      r_phase_cnt   <= r_phase_buf ? PHASE_RELOAD : r_phase_cnt + 3'd1;
      r_load        <= (r_phase_cnt == offset_i);
      r_frame_start <= r_load;
      if (r_load) begin
        r_shift    <= w_word;
        r_training <= !w_data_mode;
      end else begin
        r_shift <= {4'h0, r_shift[31:4]};
      end
    end
  end

  assign cout_o        = r_shift[3:0];
  assign frame_start_o = r_frame_start;
  assign training_o    = r_training;

endmodule
